// File: rtl/test_i11959_if.sv
// Bundles the five data inputs and the detection output of test_i11959 so a
// driver and a monitor can share them as one connection.
//   n[0..4] : data inputs N0..N4 (n[0] is N0)
//   z       : detection output Z
// The master modport drives the data and reads the detection result.
// The slave modport is the design-side view.
interface test_i11959_if;
  logic [4:0] n;
  logic       z;

  modport master (output n, input z);
  modport slave  (input n, output z);
endinterface

// File: rtl/test_i11959.sv
// test_i11959 : small registered pattern detector.
//   N0..N4 : 1-bit data inputs
//   CK     : clock, rising edge
//   reset  : asynchronous active-high reset, clears all state
//   Z      : detection output, combinational from state and N4
// Three single-bit registers capture simple gate functions of the inputs.
// c trails a by one cycle so that a & ~c flags a rising a.
// A saturating 3-bit counter counts cycles on which all inputs are 1.
// Once the counter saturates, the trigger inverts the detection output.
module test_i11959 (
  input  logic N0,
  input  logic N1,
  input  logic N2,
  input  logic N3,
  input  logic N4,
  input  logic CK,
  input  logic reset,
  output logic Z
);

  logic       a;
  logic       b;
  logic       c;
  logic [2:0] cnt;
  logic       t;
  logic       all_ones;

  assign all_ones = N0 & N1 & N2 & N3 & N4;

  // Registered stage: a, b, c and the saturating counter.
  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      a   <= 1'b0;
      b   <= 1'b0;
      c   <= 1'b0;
      cnt <= 3'd0;
    end else begin
      a <= ~(N0 & N1);
      b <= ~(N2 | N4);
      // The pre-edge value of a is used here, so c lags a by one cycle.
      c <= a ^ N3;
      if (all_ones && (cnt != 3'd7)) begin
        cnt <= cnt + 3'd1;
      end
    end
  end

  // Output stage: N4 feeds Z directly, so Z reacts without a clock edge.
  assign t = (cnt == 3'd7);
  assign Z = ((a & ~c) | (b & N4)) ^ t;

endmodule

// File: tb/tb_test_i11959.sv
module tb_test_i11959;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  bit   exp_q[$];
  bit   exp;

  // Reference model state for the randomized scenario.
  bit       ma, mb, mc;
  bit [2:0] mcnt;

  test_i11959_if bus ();

  test_i11959 dut (
    .N0    (bus.n[0]),
    .N1    (bus.n[1]),
    .N2    (bus.n[2]),
    .N3    (bus.n[3]),
    .N4    (bus.n[4]),
    .CK    (clk),
    .reset (rst),
    .Z     (bus.z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    bus.n = 5'd0;
    #1;
    for (int i = 0; i < 32; i++) begin
      bus.n = 5'(i);
      exp_q.push_back(1'b0);
      #1;
      exp = exp_q.pop_front();
      tests++;
      if (bus.z !== exp) begin
        fails++;
        $display("FAIL reset_comb n=%0d: Z=%b expected %b", i, bus.z, exp);
      end
      exp_q.push_back(1'b0);
      tick();
      exp = exp_q.pop_front();
      tests++;
      if (bus.z !== exp) begin
        fails++;
        $display("FAIL reset_edge n=%0d: Z=%b expected %b", i, bus.z, exp);
      end
    end
    tests++;
    if (dut.cnt !== 3'd0) begin
      fails++;
      $display("FAIL reset_cnt: cnt=%0d expected 0", dut.cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_zeros();
    bit zexp[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    rst = 1'b1;
    #1;
    rst   = 1'b0;
    bus.n = 5'b00000;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(zexp[i]);
      tick();
      exp = exp_q.pop_front();
      tests++;
      if (bus.z !== exp) begin
        fails++;
        $display("FAIL zeros_edge%0d: Z=%b expected %b", i + 1, bus.z, exp);
      end
      if (i == 0) begin
        tests++;
        if ({dut.a, dut.b, dut.c} !== 3'b110) begin
          fails++;
          $display("FAIL zeros_abc: abc=%b expected 110", {dut.a, dut.b, dut.c});
        end
      end
    end
  endtask

  task automatic test_n4_comb();
    rst = 1'b1;
    #1;
    rst   = 1'b0;
    bus.n = 5'b00011; // N0=1 N1=1 N2=0 N3=0 N4=0
    exp_q.push_back(1'b0);
    tick();
    exp = exp_q.pop_front();
    tests++;
    if (bus.z !== exp) begin
      fails++;
      $display("FAIL n4_edge: Z=%b expected %b", bus.z, exp);
    end
    tests++;
    if ({dut.a, dut.b} !== 2'b01) begin
      fails++;
      $display("FAIL n4_ab: ab=%b expected 01", {dut.a, dut.b});
    end
    bus.n[4] = 1'b1;
    exp_q.push_back(1'b1);
    #1;
    exp = exp_q.pop_front();
    tests++;
    if (bus.z !== exp) begin
      fails++;
      $display("FAIL n4_rise: Z=%b expected %b", bus.z, exp);
    end
    bus.n[4] = 1'b0;
    exp_q.push_back(1'b0);
    #1;
    exp = exp_q.pop_front();
    tests++;
    if (bus.z !== exp) begin
      fails++;
      $display("FAIL n4_fall: Z=%b expected %b", bus.z, exp);
    end
  endtask

  task automatic test_saturate();
    rst = 1'b1;
    #1;
    rst   = 1'b0;
    bus.n = 5'b11111;
    for (int i = 1; i <= 9; i++) begin
      exp_q.push_back(i >= 7);
      tick();
      exp = exp_q.pop_front();
      tests++;
      if (bus.z !== exp) begin
        fails++;
        $display("FAIL sat_edge%0d: Z=%b expected %b", i, bus.z, exp);
      end
      if (i == 7 || i == 9) begin
        tests++;
        if (dut.cnt !== 3'd7) begin
          fails++;
          $display("FAIL sat_cnt%0d: cnt=%0d expected 7", i, dut.cnt);
        end
      end
    end
  endtask

  task automatic test_after_sat();
    bus.n = 5'b00000;
    for (int i = 1; i <= 2; i++) begin
      exp_q.push_back(i == 2);
      tick();
      exp = exp_q.pop_front();
      tests++;
      if (bus.z !== exp) begin
        fails++;
        $display("FAIL after_sat_edge%0d: Z=%b expected %b", i, bus.z, exp);
      end
    end
    tests++;
    if (dut.cnt !== 3'd7) begin
      fails++;
      $display("FAIL after_sat_cnt: cnt=%0d expected 7", dut.cnt);
    end
  endtask

  task automatic test_reset_pulse();
    bit zexp[3] = '{1'b1, 1'b0, 1'b0};
    bus.n = 5'b00000;
    rst   = 1'b1;
    exp_q.push_back(1'b0);
    #1;
    exp = exp_q.pop_front();
    tests++;
    if (bus.z !== exp || dut.cnt !== 3'd0) begin
      fails++;
      $display("FAIL pulse_clear: Z=%b cnt=%0d expected Z=%b cnt=0", bus.z, dut.cnt, exp);
    end
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(zexp[i]);
      tick();
      exp = exp_q.pop_front();
      tests++;
      if (bus.z !== exp) begin
        fails++;
        $display("FAIL pulse_edge%0d: Z=%b expected %b", i + 1, bus.z, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [4:0] n;
    rst = 1'b1;
    #1;
    rst  = 1'b0;
    ma   = 1'b0;
    mb   = 1'b0;
    mc   = 1'b0;
    mcnt = 3'd0;
    for (int i = 0; i < 200; i++) begin
      n = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 2) == 0) n = 5'b11111;
      bus.n = n;
      // Model the edge: c takes the old a.
      mc = ma ^ n[3];
      ma = ~(n[0] & n[1]);
      mb = ~(n[2] | n[4]);
      if (n == 5'b11111 && mcnt != 3'd7) mcnt = mcnt + 3'd1;
      exp_q.push_back(((ma & ~mc) | (mb & n[4])) ^ (mcnt == 3'd7));
      tick();
      exp = exp_q.pop_front();
      tests++;
      if (bus.z !== exp) begin
        fails++;
        $display("FAIL random_%0d n=%b: Z=%b expected %b", i, n, bus.z, exp);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    bus.n = 5'd0;
    tick();
    test_reset();
    test_zeros();
    test_n4_comb();
    test_saturate();
    test_after_sat();
    test_reset_pulse();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/test_i11959.md
TEST_I11959 -- requirements
Module: test_i11959

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed.
REQ-002 Port CK: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 Port reset: input, 1 bit, asynchronous active-high reset.
REQ-004 Port N0: input, 1 bit, data input 0 (first data port in positional order).
REQ-005 Port N1: input, 1 bit, data input 1.
REQ-006 Port N2: input, 1 bit, data input 2.
REQ-007 Port N3: input, 1 bit, data input 3.
REQ-008 Port N4: input, 1 bit, data input 4.
REQ-009 Port Z: output, 1 bit, detection output.
REQ-010 The positional port order SHALL be N0, N1, N2, N3, N4, CK, reset, Z.

Function
REQ-011 The module SHALL hold state registers a, b and c (1 bit each) and cnt (3 bits, unsigned).
REQ-012 On each rising CK edge while reset is low, a SHALL load NOT(N0 AND N1).
REQ-013 On each rising CK edge while reset is low, b SHALL load NOT(N2 OR N4).
REQ-014 On each rising CK edge while reset is low, c SHALL load (pre-edge value of a) XOR N3, giving c one cycle of lag behind a.
REQ-015 cnt SHALL increment by 1 on a rising edge when N0..N4 are all 1 and cnt is below 7.
REQ-016 cnt SHALL saturate at 7 and never wrap.
REQ-017 cnt SHALL hold its value when any of N0..N4 is 0; it does not clear on a non-matching pattern.
REQ-018 Trigger t SHALL be 1 exactly when cnt equals 7.
REQ-019 Z SHALL be combinational: Z = ((a AND NOT c) OR (b AND N4)) XOR t.
REQ-020 Z SHALL respond to a change on N4 within the same cycle, with no clock edge required.
REQ-021 All other inputs SHALL affect Z only through the registers, with one cycle of latency.
REQ-022 Inputs changing between edges SHALL have no effect on a, b, c or cnt until the next rising edge.

Reset
REQ-023 While reset is high, a, b, c and cnt SHALL be forced to 0 immediately, independent of CK.
REQ-024 With all state at 0, Z SHALL read 0 for any input value.
REQ-025 Reset SHALL take priority over any simultaneous clock edge.
REQ-026 On the first rising edge after reset falls, the registers SHALL load normally.
REQ-027 Reset asserted mid-operation SHALL discard all accumulated state, including a saturated cnt, and clear t.

Verification
REQ-028 Reset high, N cycled through all 32 values with clock running -> Z = 0 throughout.
REQ-029 After reset, hold N=00000 (N0..N4):
- after edge 1, a=1, b=1, c=0, Z=1;
- after edge 2, c=1, Z=0;
- Z stays 0 on later edges.
REQ-030 After reset, apply N0..N4=1,1,0,0,0 for one edge -> a=0, b=1, Z=0; then raise N4 with no clock edge -> Z=1 immediately; drop N4 -> Z=0.
REQ-031 After reset, hold N=11111:
- Z = 0 after edges 1 to 6;
- after edge 7, cnt=7 and Z=1;
- Z stays 1 on further edges.
REQ-032 After cnt saturates, apply N=00000 -> cnt holds at 7 and Z = NOT((a AND NOT c) OR (b AND N4)): after edge 1 Z=0, after edge 2 Z=1.
REQ-033 After cnt saturates, pulse reset between clock edges -> Z=0 at once, cnt=0; re-check REQ-029 on the following edges.
